// File: rtl/param_bus_datapath.sv
// Single-bus CPU datapath: GPRs, HI/LO, Y/Z, PC, IR, MAR/MDR, I/O ports and CON flip-flop
// around one OR-combined bus, with a handshaked wait-state/timeout memory interface.
//
// state   | meaning
// IDLE    | no memory transaction outstanding
// RD_WAIT | read issued, waiting for mem_ack (MDR loads rdata on ack)
// WR_WAIT | write issued, waiting for mem_ack
module param_bus_datapath #(
  parameter int WIDTH       = 32,
  parameter int NREGS       = 16,
  parameter int IMM_W       = 19,
  parameter int R0_ZERO     = 1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic [NREGS+7:0]     src_oe,
  input  logic [NREGS+8:0]     dst_en,
  input  logic                 z_in,
  input  logic                 inc_pc,
  input  logic                 mem_rd,
  input  logic                 mem_wr,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WIDTH-1:0]     mem_addr,
  output logic [WIDTH-1:0]     mem_wdata,
  input  logic [WIDTH-1:0]     mem_rdata,
  input  logic                 mem_ack,
  output logic                 mem_busy,
  output logic                 mem_err,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  input  logic [2*WIDTH-1:0]   alu_c,
  output logic [WIDTH-1:0]     bus,
  output logic [WIDTH-1:0]     ir,
  output logic                 bus_conflict,
  input  logic                 inport_strobe,
  input  logic [WIDTH-1:0]     inport_data,
  output logic [WIDTH-1:0]     outport,
  output logic                 con_out
);

  localparam int N   = NREGS;
  localparam int SW  = NREGS + 8;
  localparam int EXT = WIDTH - IMM_W;
  localparam int CW  = $clog2(MEM_TIMEOUT + 1);

  localparam int S_HI = N,     S_LO = N + 1, S_ZHI = N + 2, S_ZLO = N + 3;
  localparam int S_PC = N + 4, S_MDR = N + 5, S_IN = N + 6, S_CSIGN = N + 7;
  localparam int D_HI = N,     D_LO = N + 1, D_Y = N + 2,   D_PC = N + 3, D_IR = N + 4;
  localparam int D_MAR = N + 5, D_MDR = N + 6, D_OUT = N + 7, D_CON = N + 8;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} mem_state_e;

  logic [WIDTH-1:0] gpr_q [NREGS];
  logic [WIDTH-1:0] gpr_d [NREGS];
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, y_q, y_d, zhi_q, zhi_d, zlo_q, zlo_d;
  logic [WIDTH-1:0] pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
  logic [WIDTH-1:0] in_q, in_d, out_q, out_d;
  logic             con_q, con_d, conflict_q, conflict_d;

  mem_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic             mem_req_q, mem_we_q, mem_err_q;
  logic [WIDTH-1:0] mem_addr_q, mem_wdata_q;

  logic [WIDTH-1:0] bus_val, csign;
  logic             multi_src, con_cond, rd_done;

  assign csign     = {{EXT{ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
  assign multi_src = |(src_oe & (src_oe - SW'(1)));
  assign rd_done   = (state_q == RD_WAIT) && mem_ack;

  always_comb begin
    bus_val = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (src_oe[i] && !(R0_ZERO != 0 && i == 0)) bus_val = bus_val | gpr_q[i];
    end
    if (src_oe[S_HI])    bus_val = bus_val | hi_q;
    if (src_oe[S_LO])    bus_val = bus_val | lo_q;
    if (src_oe[S_ZHI])   bus_val = bus_val | zhi_q;
    if (src_oe[S_ZLO])   bus_val = bus_val | zlo_q;
    if (src_oe[S_PC])    bus_val = bus_val | pc_q;
    if (src_oe[S_MDR])   bus_val = bus_val | mdr_q;
    if (src_oe[S_IN])    bus_val = bus_val | in_q;
    if (src_oe[S_CSIGN]) bus_val = bus_val | csign;
  end

  always_comb begin
    con_cond = 1'b0;
    case (ir_q[IMM_W+1:IMM_W])
      2'b00:   con_cond = (bus_val == '0);
      2'b01:   con_cond = (bus_val != '0);
      2'b10:   con_cond = ~bus_val[WIDTH-1];
      default: con_cond = bus_val[WIDTH-1];
    endcase
  end

  always_comb begin
    gpr_d = gpr_q;
    for (int i = 0; i < NREGS; i++) begin
      if (dst_en[i]) gpr_d[i] = bus_val;
    end
    if (R0_ZERO != 0) gpr_d[0] = '0;
    hi_d  = dst_en[D_HI]  ? bus_val : hi_q;
    lo_d  = dst_en[D_LO]  ? bus_val : lo_q;
    y_d   = dst_en[D_Y]   ? bus_val : y_q;
    ir_d  = dst_en[D_IR]  ? bus_val : ir_q;
    mar_d = dst_en[D_MAR] ? bus_val : mar_q;
    out_d = dst_en[D_OUT] ? bus_val : out_q;
    con_d = dst_en[D_CON] ? con_cond : con_q;
    in_d  = inport_strobe ? inport_data : in_q;
    zhi_d = z_in ? alu_c[2*WIDTH-1:WIDTH] : zhi_q;
    zlo_d = z_in ? alu_c[WIDTH-1:0] : zlo_q;
    if (dst_en[D_PC])  pc_d = bus_val;
    else if (inc_pc)   pc_d = pc_q + WIDTH'(1);
    else               pc_d = pc_q;
    // Returning read data wins over a bus load in the same cycle.
    if (rd_done)            mdr_d = mem_rdata;
    else if (dst_en[D_MDR]) mdr_d = bus_val;
    else                    mdr_d = mdr_q;
    conflict_d = conflict_q | multi_src;
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      gpr_q      <= '{default: '0};
      hi_q       <= '0;
      lo_q       <= '0;
      y_q        <= '0;
      zhi_q      <= '0;
      zlo_q      <= '0;
      pc_q       <= '0;
      ir_q       <= '0;
      mar_q      <= '0;
      mdr_q      <= '0;
      in_q       <= '0;
      out_q      <= '0;
      con_q      <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      gpr_q      <= gpr_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      y_q        <= y_d;
      zhi_q      <= zhi_d;
      zlo_q      <= zlo_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      mar_q      <= mar_d;
      mdr_q      <= mdr_d;
      in_q       <= in_d;
      out_q      <= out_d;
      con_q      <= con_d;
      conflict_q <= conflict_d;
    end
  end

  // cnt_q holds the remaining wait cycles after the current one; zero with no ack is a timeout.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_rd && mem_wr) begin
            mem_err_q <= 1'b1;
          end else if (mem_rd) begin
            state_q    <= RD_WAIT;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= mar_q;
            cnt_q      <= CW'(MEM_TIMEOUT - 1);
          end else if (mem_wr) begin
            state_q     <= WR_WAIT;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= mar_q;
            mem_wdata_q <= mdr_q;
            cnt_q       <= CW'(MEM_TIMEOUT - 1);
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (mem_ack) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus          = bus_val;
  assign alu_a        = y_q;
  assign alu_b        = bus_val;
  assign ir           = ir_q;
  assign outport      = out_q;
  assign con_out      = con_q;
  assign bus_conflict = conflict_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_busy     = mem_req_q;
  assign mem_err      = mem_err_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

endmodule
